// File: rtl/sp_pkg.sv
// sp_pkg: shared types and helpers for the serial/parallel converter blocks
package sp_pkg;
    typedef enum logic {LSB_FIRST = 1'b0, MSB_FIRST = 1'b1} bit_order_e;
    function automatic int sp_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction
endpackage

// File: rtl/sp_out_reg.sv
// sp_out_reg: WIDTH-wide valid/ready holding register; data only changes on load
module sp_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             m_ready,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    always_comb begin
        valid_d = load | (valid_q & ~m_ready);
        data_d  = load ? load_data : data_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
    assign m_valid = valid_q;
    assign m_data  = data_q;
endmodule

// File: rtl/sp_deserializer.sv
// sp_deserializer: collects WIDTH serial bits into a word with valid/ready on both sides
module sp_deserializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = sp_pkg::sp_cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic             s_data,
    input  logic             s_start,
    output logic             s_ready,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             frame_err
);
    import sp_pkg::*;
    localparam bit_order_e ORDER = (MSB_FIRST != 0) ? sp_pkg::MSB_FIRST : LSB_FIRST;
    logic [WIDTH-1:0] shreg_q, shreg_d, base, word, load_data;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d, cnt_base;
    logic             pending_q, pending_d, frame_err_q, frame_err_d;
    logic             acc, done, free, load;
    always_comb begin
        acc         = s_valid & ~pending_q;
        free        = ~m_valid | m_ready;
        base        = s_start ? '0 : shreg_q;
        cnt_base    = s_start ? '0 : bit_cnt_q;
        word        = (ORDER == sp_pkg::MSB_FIRST) ? WIDTH'({base, s_data}) : WIDTH'({s_data, base} >> 1);
        done        = acc & (cnt_base == CNT_W'(WIDTH - 1));
        bit_cnt_d   = acc ? (done ? '0 : cnt_base + CNT_W'(1)) : bit_cnt_q;
        shreg_d     = acc ? word : shreg_q;
        // a finished word waits in the shifter until the output slot drains
        pending_d   = pending_q ? ~m_ready : done & ~free;
        load        = pending_q ? m_ready : done & free;
        load_data   = pending_q ? shreg_q : word;
        frame_err_d = acc & s_start & (bit_cnt_q != '0);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            pending_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            pending_q   <= pending_d;
            frame_err_q <= frame_err_d;
        end
    end
    sp_out_reg #(.WIDTH(WIDTH)) u_out (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_data(load_data),
        .m_ready  (m_ready),
        .m_valid  (m_valid),
        .m_data   (m_data)
    );
    assign s_ready   = ~pending_q;
    assign bit_cnt   = bit_cnt_q;
    assign frame_err = frame_err_q;
endmodule
